vm_controller: RTL and testbench

Transaction controller for the vending machine. It takes debounced nickel/dime button levels and edge-detects them, merging simultaneous coins into one credit update. It holds the running credit and sequences dispense and change return as timed output phases. It drives the product-release line, change pulses and credit display in place of the bare coin-counting state machine.

---
 rtl/vm_pkg.sv | 28 ++
 rtl/vm_edge_detect.sv | 28 ++
 rtl/vm_controller.sv | 180 ++++++++++++++++++
 tb/tb_vm_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine transaction controller.
// Holds the one-hot FSM encodings, the coin values in nickels, the credit width and a
// helper that adds one cycle's coin events to the running credit.
// Optional feature macro used by the design: VM_CANCEL_EN (refund on CANCEL edge).
package vm_pkg;

  localparam int unsigned CREDIT_W    = 4;
  localparam int unsigned COIN_NICKEL = 1;
  localparam int unsigned COIN_DIME   = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b001,
    ST_DISPENSE = 3'b010,
    ST_CHANGE   = 3'b100
  } vm_state_e;

  // One extra bit so credit plus a simultaneous nickel and dime never truncates.
  function automatic logic [CREDIT_W:0] coin_sum(input logic [CREDIT_W-1:0] credit,
                                                 input logic                nickel,
                                                 input logic                dime);
    logic [CREDIT_W:0] sum;
    sum = {1'b0, credit};
    if (nickel) sum = sum + (CREDIT_W + 1)'(COIN_NICKEL);
    if (dime)   sum = sum + (CREDIT_W + 1)'(COIN_DIME);
    return sum;
  endfunction

endpackage

// File: rtl/vm_edge_detect.sv
// One-bit rising-edge detector for debounced button levels.
// The previous-sample register resets to 1, so a level already high when reset releases
// does not produce an edge until it has been released and pressed again.
// Ports:
//   i_clk   - clock, posedge
//   i_reset - synchronous active-high reset
//   i_level - debounced input level
//   o_rise  - high in the cycle the level is high but was low on the previous edge
module vm_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/vm_controller.sv
// Vending-machine transaction controller.
// Edge-detects the nickel/dime buttons, accumulates credit, runs a timed dispense phase
// when credit reaches PRICE, then returns any remaining credit as spaced CHG pulses.
// Coins arriving while busy are discarded and flagged with REJECT.
// Optional feature: define VM_CANCEL_EN to add the CANCEL input and the refund path.
// Ports:
//   CLK    - clock, posedge
//   RESET  - synchronous active-high reset
//   N, D   - debounced nickel / dime button levels
//   CANCEL - refund request level (VM_CANCEL_EN only)
//   State  - current credit in nickels
//   O      - product release, high for DISP_LEN cycles per dispense
//   CHG    - one-cycle pulse per nickel returned
//   REJECT - one-cycle pulse for a coin edge seen while busy
//   BUSY   - high while dispensing or returning change
module vm_controller
  import vm_pkg::*;
#(
  parameter int unsigned PRICE    = 3,
  parameter int unsigned DISP_LEN = 4,
  parameter int unsigned CHG_GAP  = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                N,
  input  logic                D,
`ifdef VM_CANCEL_EN
  input  logic                CANCEL,
`endif
  output logic [CREDIT_W-1:0] State,
  output logic                O,
  output logic                CHG,
  output logic                REJECT,
  output logic                BUSY
);

  localparam logic [CREDIT_W:0] LP_PRICE    = (CREDIT_W + 1)'(PRICE);
  localparam logic [7:0]        LP_DISP_LEN = 8'(DISP_LEN);
  localparam logic [7:0]        LP_CHG_GAP  = 8'(CHG_GAP);

  vm_state_e           r_state, w_state_d;
  logic [CREDIT_W-1:0] r_credit, w_credit_d;
  logic [7:0]          r_timer, w_timer_d;
  logic                r_chg, w_chg_d;
  logic                r_reject, w_reject_d;
  logic                r_o;
  logic                r_busy;

  logic                w_n_evt;
  logic                w_d_evt;
  logic                w_cancel_evt;
  logic                w_coin_evt;
  logic [CREDIT_W:0]   w_credit_next;

  vm_edge_detect u_edge_n (
    .i_clk   (CLK),
    .i_reset (RESET),
    .i_level (N),
    .o_rise  (w_n_evt)
  );

  vm_edge_detect u_edge_d (
    .i_clk   (CLK),
    .i_reset (RESET),
    .i_level (D),
    .o_rise  (w_d_evt)
  );

`ifdef VM_CANCEL_EN
  vm_edge_detect u_edge_c (
    .i_clk   (CLK),
    .i_reset (RESET),
    .i_level (CANCEL),
    .o_rise  (w_cancel_evt)
  );
`else
  assign w_cancel_evt = 1'b0;
`endif

  assign w_coin_evt    = w_n_evt | w_d_evt;
  assign w_credit_next = coin_sum(r_credit, w_n_evt, w_d_evt);

  always_comb begin
    w_state_d  = r_state;
    w_credit_d = r_credit;
    w_timer_d  = r_timer;
    w_chg_d    = 1'b0;
    w_reject_d = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // Cancel beats dispense: the coin is added first and the whole sum refunded.
        if (w_cancel_evt && (w_credit_next != '0)) begin
          w_state_d  = ST_CHANGE;
          w_credit_d = w_credit_next[CREDIT_W-1:0];
          w_chg_d    = 1'b1;
          w_timer_d  = '0;
        end else if (w_credit_next >= LP_PRICE) begin
          w_state_d  = ST_DISPENSE;
          w_credit_d = CREDIT_W'(w_credit_next - LP_PRICE);
          w_timer_d  = LP_DISP_LEN;
        end else begin
          w_credit_d = w_credit_next[CREDIT_W-1:0];
        end
      end

      ST_DISPENSE: begin
        w_reject_d = w_coin_evt;
        if (r_timer <= 8'd1) begin
          w_timer_d = '0;
          if (r_credit != '0) begin
            // First change pulse immediately follows the last dispense cycle.
            w_state_d = ST_CHANGE;
            w_chg_d   = 1'b1;
          end else begin
            w_state_d = ST_IDLE;
          end
        end else begin
          w_timer_d = r_timer - 8'd1;
        end
      end

      ST_CHANGE: begin
        w_reject_d = w_coin_evt;
        if (r_chg) begin
          // Credit drops on the edge that ends the pulse cycle.
          w_credit_d = (r_credit != '0) ? (r_credit - CREDIT_W'(1)) : '0;
          if (r_credit <= CREDIT_W'(1)) begin
            w_state_d = ST_IDLE;
            w_timer_d = '0;
          end else if (LP_CHG_GAP <= 8'd1) begin
            w_chg_d   = 1'b1;
            w_timer_d = '0;
          end else begin
            // Counts the idle cycles between pulses; the pulse cycle itself is one of CHG_GAP.
            w_timer_d = LP_CHG_GAP - 8'd1;
          end
        end else if (r_timer <= 8'd1) begin
          w_chg_d   = 1'b1;
          w_timer_d = '0;
        end else begin
          w_timer_d = r_timer - 8'd1;
        end
      end

      default: begin
        w_state_d  = ST_IDLE;
        w_credit_d = '0;
        w_timer_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_credit <= '0;
      r_timer  <= '0;
      r_chg    <= 1'b0;
      r_reject <= 1'b0;
      r_o      <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_credit <= w_credit_d;
      r_timer  <= w_timer_d;
      r_chg    <= w_chg_d;
      r_reject <= w_reject_d;
      r_o      <= (w_state_d == ST_DISPENSE);
      r_busy   <= (w_state_d != ST_IDLE);
    end
  end

  assign State  = r_credit;
  assign O      = r_o;
  assign CHG    = r_chg;
  assign REJECT = r_reject;
  assign BUSY   = r_busy;

endmodule

// File: tb/tb_vm_controller.sv
// Randomized scoreboard bench for vm_controller. A transaction-level model turns each
// stimulus cycle into expected dispense starts, change-pulse cycles and reject cycles
// (queued), plus expected State/O/BUSY per cycle; a monitor compares on every negedge.
module tb_vm_controller;

  localparam int P     = 3;
  localparam int DL    = 4;
  localparam int G     = 2;
  localparam int NCYC  = 2500;
  localparam int DEPTH = 8192;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       N;
  logic       D;
`ifdef VM_CANCEL_EN
  logic       CANCEL;
`endif
  logic [3:0] State;
  logic       O;
  logic       CHG;
  logic       REJECT;
  logic       BUSY;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  int q_o[$];
  int q_chg[$];
  int q_rej[$];

  bit exp_valid[DEPTH];
  int exp_state[DEPTH];
  bit exp_o[DEPTH];
  bit exp_busy[DEPTH];

  // Model state: idle credit, active transaction window and pulse schedule.
  int m_credit = 0;
  int m_r      = 0;
  int m_start  = 0;
  int m_olo    = 1;
  int m_ohi    = 0;
  int m_blo    = 1;
  int m_bhi    = 0;
  int m_free   = 0;
  bit pn = 1'b1, pd = 1'b1, pc = 1'b1;

  vm_controller #(
    .PRICE    (P),
    .DISP_LEN (DL),
    .CHG_GAP  (G)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .N      (N),
    .D      (D),
`ifdef VM_CANCEL_EN
    .CANCEL (CANCEL),
`endif
    .State  (State),
    .O      (O),
    .CHG    (CHG),
    .REJECT (REJECT),
    .BUSY   (BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Drive one cycle of inputs and predict the consequences of the coming edge e.
  task automatic step(input bit n, input bit d, input bit c, input bit r);
    int e, sum, pulses;
    bit evn, evd, evc;
    @(negedge CLK);
    N = n;
    D = d;
    RESET = r;
`ifdef VM_CANCEL_EN
    CANCEL = c;
    evc = c & ~pc;
`else
    evc = 1'b0;
`endif
    e   = cyc + 1;
    evn = n & ~pn;
    evd = d & ~pd;
    pn  = n;
    pd  = d;
    pc  = c;
    if (r) begin
      pn = 1'b1; pd = 1'b1; pc = 1'b1;
      m_credit = 0; m_r = 0;
      m_olo = 1; m_ohi = 0; m_blo = 1; m_bhi = 0;
      m_free = e + 1;
      while (q_o.size() > 0 && q_o[$] > cyc) void'(q_o.pop_back());
      while (q_chg.size() > 0 && q_chg[$] > cyc) void'(q_chg.pop_back());
      while (q_rej.size() > 0 && q_rej[$] > cyc) void'(q_rej.pop_back());
    end else if (e >= m_free) begin
      sum = m_credit + (evn ? 1 : 0) + (evd ? 2 : 0);
      if (evc && sum > 0) begin
        m_r = sum; m_start = e; m_olo = 1; m_ohi = 0;
        for (int i = 0; i < sum; i++) q_chg.push_back(e + i * G);
        m_free = e + (sum - 1) * G + 2;
        m_blo = e; m_bhi = m_free - 2; m_credit = 0;
      end else if (sum >= P) begin
        m_r = sum - P; m_olo = e; m_ohi = e + DL - 1;
        q_o.push_back(e);
        m_start = e + DL;
        if (m_r > 0) begin
          for (int i = 0; i < m_r; i++) q_chg.push_back(m_start + i * G);
          m_free = m_start + (m_r - 1) * G + 2;
        end else begin
          m_free = e + DL + 1;
        end
        m_blo = e; m_bhi = m_free - 2; m_credit = 0;
      end else begin
        m_credit = sum;
      end
    end else if (evn || evd) begin
      q_rej.push_back(e);
    end
    if (e >= m_blo && e <= m_bhi) begin
      exp_busy[e] = 1'b1;
      exp_o[e]    = (e >= m_olo && e <= m_ohi);
      if (m_r == 0 || e <= m_start) pulses = 0;
      else pulses = (e - m_start - 1) / G + 1;
      if (pulses > m_r) pulses = m_r;
      exp_state[e] = m_r - pulses;
    end else begin
      exp_busy[e]  = 1'b0;
      exp_o[e]     = 1'b0;
      exp_state[e] = m_credit;
    end
    exp_valid[e] = !r || 1'b1;
  endtask

  // Monitor: per-cycle level checks plus scoreboard pops on output events.
  initial begin
    bit prev_o;
    int lbl;
    int ex;
    prev_o = 1'b0;
    forever begin
      @(negedge CLK);
      lbl = cyc;
      if (lbl < DEPTH && exp_valid[lbl]) begin
        check("state", int'(State), exp_state[lbl]);
        check("o_level", int'(O), int'(exp_o[lbl]));
        check("busy", int'(BUSY), int'(exp_busy[lbl]));
        if (O && !prev_o) begin
          if (q_o.size() == 0) begin
            tests++; fails++;
            $display("FAIL dispense_start at cycle %0d: got unexpected O rise, expected none", lbl);
          end else begin
            ex = q_o.pop_front();
            check("dispense_start", lbl, ex);
          end
        end
        if (CHG) begin
          if (q_chg.size() == 0) begin
            tests++; fails++;
            $display("FAIL chg_pulse at cycle %0d: got unexpected pulse, expected none", lbl);
          end else begin
            ex = q_chg.pop_front();
            check("chg_pulse", lbl, ex);
          end
        end
        if (REJECT) begin
          if (q_rej.size() == 0) begin
            tests++; fails++;
            $display("FAIL reject at cycle %0d: got unexpected pulse, expected none", lbl);
          end else begin
            ex = q_rej.pop_front();
            check("reject", lbl, ex);
          end
        end
      end
      prev_o = O;
    end
  end

  initial begin
    bit n, d, c, r;
    RESET = 1'b1;
    N = 1'b0;
    D = 1'b0;
`ifdef VM_CANCEL_EN
    CANCEL = 1'b0;
`endif
    repeat (3) step(0, 0, 0, 1);
    // Simultaneous nickel and dime from zero credit.
    step(1, 1, 0, 0);
    repeat (8) step(0, 0, 0, 0);
    // Three nickels, spaced.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    end
    repeat (6) step(0, 0, 0, 0);
    // Two dimes, then nickel presses during dispense and change.
    step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0);
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    // Credit 2 then cancel (held credit when the refund path is absent).
    step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 0, 1, 0);
    repeat (10) step(0, 0, 0, 0);
    // Reset in change with N held, then release and re-press.
    step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0);
    repeat (DL) step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    repeat (4) step(1, 0, 0, 0);
    step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    // Randomized traffic.
    n = 0; d = 0; c = 0;
    for (int i = 0; i < NCYC; i++) begin
      if ($urandom_range(3) == 0) n = ~n;
      if ($urandom_range(4) == 0) d = ~d;
      if ($urandom_range(7) == 0) c = ~c;
      r = ($urandom_range(199) == 0);
      step(n, d, c, r);
    end
    repeat (40) step(0, 0, 0, 0);
    repeat (2) @(negedge CLK);
    check("pending_dispense", q_o.size(), 0);
    check("pending_chg", q_chg.size(), 0);
    check("pending_reject", q_rej.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
